clk_div_period_meter: RTL and testbench

- Receive-side companion to the even clock dividers: it measures a divided or external square wave, e.g. a divider output, Hall sensor or encoder channel.
- Synchronizes the input, detects edges, and reports high-time, low-time and full period in system-clock cycles.
- Sits beside the divider bank in the PMSM control logic for self-check of divided clocks and speed estimation.
- Flags loss of signal with a timeout.

---
 rtl/clk_div_period_meter.sv | 101 ++++++++++
 tb/tb_clk_div_period_meter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_period_meter.sv
// clk_div_period_meter: measures high time, low time and period of an asynchronous square wave in clk cycles
module clk_div_period_meter #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] low_cnt,
  output logic [WIDTH:0]   period,
  output logic             meas_valid,
  output logic             timeout
);
  typedef enum logic [1:0] {idle, arm, meas_high, meas_low} state_t;
  localparam logic [WIDTH-1:0] tmo_lim = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] cnt_max = {WIDTH{1'b1}};
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, fall, edge_seen, tmo;
  logic [WIDTH-1:0] cnt, cnt_n, high_n, low_n;
  logic [WIDTH:0] period_n;
  logic valid_n, timeout_n;
  assign s = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign edge_seen = rise | fall;
  // an edge arriving in the same cycle as the limit wins over the timeout
  assign tmo = (cnt == tmo_lim) && !edge_seen;
  always_comb begin
    state_n = state;
    cnt_n = edge_seen ? WIDTH'(1) : (cnt == cnt_max ? cnt : cnt + 1'b1);
    high_n = high_cnt;
    low_n = low_cnt;
    period_n = period;
    valid_n = 1'b0;
    timeout_n = timeout;
    if (!enable) begin
      state_n = idle;
      cnt_n = '0;
    end else begin
      case (state)
        idle: begin
          state_n = arm;
          cnt_n = '0;
        end
        arm: state_n = rise ? meas_high : arm;
        meas_high: if (fall) begin
          high_n = cnt;
          state_n = meas_low;
        end
        meas_low: if (rise) begin
          low_n = cnt;
          period_n = {1'b0, high_cnt} + {1'b0, cnt};
          valid_n = 1'b1;
          state_n = meas_high;
        end
        default: state_n = idle;
      endcase
      if (state != idle && rise) timeout_n = 1'b0;
      if (state != idle && tmo) begin
        timeout_n = 1'b1;
        high_n = '0;
        low_n = '0;
        period_n = '0;
        state_n = arm;
      end
    end
  end
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      sync <= '0;
      s_d <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      state <= idle;
      cnt <= '0;
      high_cnt <= '0;
      low_cnt <= '0;
      period <= '0;
      meas_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d <= s;
      rise_pulse <= rise;
      fall_pulse <= fall;
      state <= state_n;
      cnt <= cnt_n;
      high_cnt <= high_n;
      low_cnt <= low_n;
      period <= period_n;
      meas_valid <= valid_n;
      timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_clk_div_period_meter.sv
// tb_clk_div_period_meter: directed checks of edge latency, measurements, timeout, enable gating and reset
module tb_clk_div_period_meter;
  logic clk = 0, global_rst = 1, enable = 0, sig_in = 0, en8 = 0, sig8 = 0;
  logic rise_pulse, fall_pulse, meas_valid, timeout;
  logic [15:0] high_cnt, low_cnt;
  logic [16:0] period;
  logic rise8, fall8, mv8, to8;
  logic [15:0] high8, low8;
  logic [16:0] p8;
  int checks = 0, errors = 0, t = 0, vcount = 0, last_v = -1, gap = 0, gap_err = 0;
  bit to8_seen = 0;

  clk_div_period_meter #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut (
    .clk(clk), .global_rst(global_rst), .enable(enable), .sig_in(sig_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .period(period), .meas_valid(meas_valid), .timeout(timeout));

  clk_div_period_meter #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(8)) dut8 (
    .clk(clk), .global_rst(global_rst), .enable(en8), .sig_in(sig8),
    .rise_pulse(rise8), .fall_pulse(fall8), .high_cnt(high8), .low_cnt(low8),
    .period(p8), .meas_valid(mv8), .timeout(to8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
      if (meas_valid === 1'b1) begin
        if (last_v >= 0 && t - last_v != gap) gap_err++;
        last_v = t;
        vcount++;
      end
      if (to8 === 1'b1) to8_seen = 1;
    end
  endtask

  task automatic mon_clear(input int g);
    vcount = 0;
    last_v = -1;
    gap = g;
    gap_err = 0;
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      sig_in = 1;
      step(h);
      sig_in = 0;
      step(l);
    end
  endtask

  initial begin
    step(2);
    chk("reset_outputs", {rise_pulse, fall_pulse, meas_valid, timeout, high_cnt, low_cnt}, 0);
    chk("reset_period", period, 0);
    global_rst = 0;
    step(1);
    // divide-by-2 source
    enable = 1;
    step(2);
    mon_clear(4);
    wave(2, 2, 5);
    chk("div2_valid_count", vcount, 4);
    chk("div2_valid_spacing", gap_err, 0);
    chk("div2_high", high_cnt, 2);
    chk("div2_low", low_cnt, 2);
    chk("div2_period", period, 4);
    enable = 0;
    step(5);
    chk("disable_hold_period", period, 4);
    enable = 1;
    step(2);
    // asymmetric 5/11 and edge latency
    sig_in = 1;
    step(2);
    chk("rise_lat_early", rise_pulse, 0);
    step(1);
    chk("rise_lat_exact", rise_pulse, 1);
    step(2);
    sig_in = 0;
    step(11);
    mon_clear(16);
    wave(5, 11, 2);
    sig_in = 1;
    step(3);
    chk("asym_valid_count", vcount, 3);
    chk("asym_valid_spacing", gap_err, 0);
    chk("asym_valid_now", meas_valid, 1);
    chk("asym_high", high_cnt, 5);
    chk("asym_low", low_cnt, 11);
    chk("asym_period", period, 16);
    // timeout after the last edge
    step(2);
    sig_in = 0;
    step(3);
    chk("last_fall_pulse", fall_pulse, 1);
    chk("last_fall_high", high_cnt, 5);
    step(19);
    chk("timeout_early", timeout, 0);
    step(1);
    chk("timeout_set", timeout, 1);
    chk("timeout_clears_results", {high_cnt, low_cnt}, 0);
    chk("timeout_clears_period", period, 0);
    chk("timeout_no_valid", vcount, 3);
    mon_clear(0);
    sig_in = 1;
    step(3);
    chk("restart_rise_pulse", rise_pulse, 1);
    chk("restart_timeout_drop", timeout, 0);
    step(2);
    sig_in = 0;
    step(11);
    sig_in = 1;
    step(3);
    chk("restart_one_valid", vcount, 1);
    chk("restart_valid_now", meas_valid, 1);
    chk("restart_period", period, 16);
    // enable gating discards partial periods
    step(1);
    enable = 0;
    step(1);
    sig_in = 0;
    mon_clear(0);
    step(11);
    sig_in = 1;
    step(2);
    enable = 1;
    step(1);
    chk("rise_pulse_in_idle", rise_pulse, 1);
    step(2);
    sig_in = 0;
    step(11);
    chk("gated_no_valid", vcount, 0);
    chk("gated_hold_high", high_cnt, 5);
    chk("gated_hold_period", period, 16);
    sig_in = 1;
    step(4);
    sig_in = 0;
    step(9);
    sig_in = 1;
    step(3);
    chk("regate_one_valid", vcount, 1);
    chk("regate_high", high_cnt, 4);
    chk("regate_low", low_cnt, 9);
    chk("regate_period", period, 13);
    // asynchronous reset in the low phase
    step(1);
    sig_in = 0;
    step(4);
    chk("pre_reset_high", high_cnt, 4);
    global_rst = 1;
    #1;
    chk("async_reset_outputs", {rise_pulse, fall_pulse, meas_valid, timeout, high_cnt, low_cnt}, 0);
    chk("async_reset_period", period, 0);
    chk("async_reset_state_idle", dut.state, 0);
    step(1);
    global_rst = 0;
    step(1);
    // edge coincident with the timeout limit
    en8 = 1;
    to8_seen = 0;
    repeat (3) begin
      sig8 = 1;
      step(3);
      sig8 = 0;
      step(8);
    end
    sig8 = 1;
    step(3);
    chk("tmo8_valid", mv8, 1);
    chk("tmo8_high", high8, 3);
    chk("tmo8_low", low8, 8);
    chk("tmo8_period", p8, 11);
    chk("tmo8_never_timed_out", to8_seen, 0);
    step(7);
    chk("tmo8_hold_early", to8, 0);
    step(1);
    chk("tmo8_hold_timeout", to8, 1);
    chk("tmo8_clears_period", p8, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
